// File: rtl/mac_array_west_feeder.sv
// West-edge transmitter for the mac_tile systolic array: accepts weight/activation vectors
// and issues them to every row with a one-cycle-per-row diagonal skew.
module mac_array_west_feeder #(
    parameter int bw  = 4,
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_load,
    input  logic                start_exec,
    input  logic [15:0]         exec_len,
    input  logic [row*bw-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [row*bw-1:0]   out_w,
    output logic [row*2-1:0]    inst_w,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // DRAIN ends once lane row-1 has shown the final slot; done is registered one cycle later.
    localparam logic [15:0] DRAIN_LAST = (row > 1) ? 16'(row - 2) : 16'd0;
    localparam logic [15:0] COL_CNT    = 16'(col);

    state_t             state_r;
    logic [15:0]        count_r;
    logic [15:0]        drain_cnt_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               accept_s;
    logic [row*bw-1:0]  slot_val_s;
    logic [1:0]         slot_inst_s;

    assign accept_s = in_valid & in_ready_r;
    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Slot entering the skew chains this cycle: accepted vector or a zero bubble.
    always_comb begin
        slot_val_s  = '0;
        slot_inst_s = 2'b00;
        if (accept_s) begin
            slot_val_s = in_data;
            case (state_r)
                LOAD:    slot_inst_s = 2'b01;
                EXEC:    slot_inst_s = 2'b10;
                default: slot_inst_s = 2'b00;
            endcase
        end else begin
            slot_val_s  = '0;
            slot_inst_s = 2'b00;
        end
    end

    // Command sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= 16'd0;
            drain_cnt_r <= 16'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (done_r) begin
                        busy_r <= 1'b0;
                    end
                    if (start_load) begin
                        state_r    <= LOAD;
                        count_r    <= COL_CNT;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else if (start_exec) begin
                        busy_r <= 1'b1;
                        if (exec_len == 16'd0) begin
                            state_r     <= DRAIN;
                            drain_cnt_r <= 16'd0;
                        end else begin
                            state_r    <= EXEC;
                            count_r    <= exec_len;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                LOAD, EXEC: begin
                    if (accept_s) begin
                        count_r <= count_r - 16'd1;
                        if (count_r == 16'd1) begin
                            state_r     <= DRAIN;
                            in_ready_r  <= 1'b0;
                            drain_cnt_r <= 16'd0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    genvar lane;
    generate
        for (lane = 0; lane < row; lane++) begin : g_lane
            logic [bw+1:0] chain_r [0:lane];

            // Lane delay line of depth lane+1; inst travels alongside its value.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int s = 0; s <= lane; s++) begin
                        chain_r[s] <= '0;
                    end
                end else begin
                    chain_r[0] <= {slot_inst_s, slot_val_s[lane*bw +: bw]};
                    for (int s = 1; s <= lane; s++) begin
                        chain_r[s] <= chain_r[s-1];
                    end
                end
            end

            assign out_w[lane*bw +: bw] = chain_r[lane][bw-1:0];
            assign inst_w[lane*2 +: 2]  = chain_r[lane][bw+1:bw];
        end
    endgenerate

endmodule
